dat_chunk_pingpong: RTL and testbench
=====================================

Name: dat_chunk_pingpong

Overview:
- Multi-bank chunk buffer for sparse activation/weight chunks; successor to the single-bank chunk combiner.
- Write side takes one BUS_SIZE-wide beat per cycle (sparsemap bits + nonzero bytes) and assembles a full MEM_SIZE chunk, with optional early termination and zero padding.
- Completed chunks are presented whole to the PE-side reader. BANK_NUM banks let the loader fill one chunk while the PE consumes another.
- Sits between the DMA/loader and the sparse PE front end.

Parameters:
MEM_SIZE, 512, chunk size in elements (sparsemap bits and nonzero bytes per chunk)
BUS_SIZE, 128, elements per write beat; MEM_SIZE % BUS_SIZE == 0
BANK_NUM, 2, number of chunk banks (>=1; power of two not required)
CYC_NUM (localparam), MEM_SIZE/BUS_SIZE, beats per full chunk
CNT_W (localparam), $clog2(MEM_SIZE+1), width of the nonzero count

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  reset, asynchronous, active-high
wr_valid_i  in  1  write beat valid
wr_ready_o  out  1  write beat accepted when wr_valid_i&&wr_ready_o
wr_sparsemap_i  in  BUS_SIZE  sparsemap bits of beat
wr_nonzero_data_i  in  BUS_SIZE*8  nonzero bytes of beat, lane l at [8l+7:8l]
wr_last_i  in  1  beat closes chunk early (padding); ignored unless accepted
rd_valid_o  out  1  a complete chunk is presented
rd_sparsemap_o  out  MEM_SIZE  presented chunk sparsemap
rd_nonzero_data_o  out  MEM_SIZE*8  presented chunk bytes, element j at [8j+7:8j]
rd_nz_count_o  out  CNT_W  popcount of rd_sparsemap_o
rd_beats_o  out  $clog2(CYC_NUM+1)  beats actually written into presented chunk (1..CYC_NUM)
rd_release_i  in  1  reader done with presented chunk
ovf_o  out  1  sticky: wr_valid_i seen while wr_ready_o low

Behaviour:
- Reset (async, rst_i=1): all banks EMPTY, all bank contents zero, wr_ptr=rd_ptr=0, beat counter 0, per-bank nz count 0. Outputs: wr_ready_o=1 (after reset deassertion), rd_valid_o=0, rd_sparsemap_o=0, rd_nonzero_data_o=0, rd_nz_count_o=0, rd_beats_o=0, ovf_o=0. Reset mid-chunk discards the partial chunk.
- Per-bank state: EMPTY -> FILLING (first beat accepted) -> FULL (closing beat accepted) -> EMPTY (release). The state bits are registered.
- wr_ready_o = (state[wr_ptr] != FULL). This is combinational from registers; there is no dependence on wr_valid_i.
- Accepted beat b (beat counter value) writes:
  - sparsemap bits [BUS_SIZE*b +: BUS_SIZE];
  - bytes for elements BUS_SIZE*b .. BUS_SIZE*b+BUS_SIZE-1 of bank wr_ptr.
- Per-bank nz count accumulates popcount(wr_sparsemap_i) for each accepted beat, in the same cycle.
- Chunk closes on an accepted beat when b==CYC_NUM-1 or wr_last_i=1:
  - bank -> FULL; beats register latched as b+1;
  - beat counter -> 0; wr_ptr -> (wr_ptr+1) mod BANK_NUM.
- Otherwise the beat counter increments.
- Padding: unwritten beats of an early-closed chunk read as zero, because bank contents are zeroed on release and at reset.
- Read side: rd_valid_o = (state[rd_ptr]==FULL). The rd_* data outputs drive bank rd_ptr contents directly: zero latency from the registered bank, stable while rd_valid_o=1. When rd_valid_o=0, rd_* data outputs show the (zeroed or partial) bank at rd_ptr and have no meaning.
- rd_release_i with rd_valid_o=1, on the next edge:
  - bank rd_ptr -> EMPTY, contents and count zeroed;
  - rd_ptr -> (rd_ptr+1) mod BANK_NUM.
- rd_release_i with rd_valid_o=0 is ignored.
- Simultaneous close of bank X and release of bank Y (X!=Y): both take effect. X==Y cannot occur because a FULL bank is not writable.
- With BANK_NUM=1: release and a new first beat cannot share a cycle, since wr_ready_o=0 while FULL. A release followed by a write in the next cycle works.
- Rejected beat (wr_valid_i=1, wr_ready_o=0): no state change except ovf_o<=1. ovf_o is cleared only by reset.
- Pointer wrap: modulo BANK_NUM, including BANK_NUM not a power of two.

Test Plan:
- Defaults (CYC_NUM=4):
  - 4 beats, sparsemap 128'h1 per beat, data lane0=8'hA0+b -> rd_valid_o=1 on the cycle after beat 3.
  - rd_sparsemap_o bits 0,128,256,384 set; element 128*b = A0+b; rd_nz_count_o=4; rd_beats_o=4.
- Early close: 2 beats of all-ones sparsemap, data 8'hFF, wr_last_i on beat 1 -> rd_beats_o=2, rd_nz_count_o=256, bits 256..511 zero, bytes 256..511 zero, including after a prior full chunk of nonzero data.
- Ping-pong: write chunk A, then chunk B without release -> wr_ready_o=0 after B closes.
  - Release A -> rd_* show B on the next cycle, wr_ready_o=1.
  - Writes during wr_ready_o=0 set ovf_o=1 and leave contents unchanged.
- Simultaneous: chunk A FULL, beat 3 of chunk B accepted while rd_release_i=1 -> next cycle rd_valid_o=1 presenting B, A bank EMPTY and zeroed, wr_ptr back to bank 0.
- Reset mid-operation: assert rst_i asynchronously (not clock-aligned) after beat 1 of a chunk -> all outputs immediately 0. After deassertion, a fresh 4-beat chunk lands in bank 0 with rd_beats_o=4 and no stale beats.
- BANK_NUM=3, MEM_SIZE=256, BUS_SIZE=64 -> 7 chunks written and released in order; pointers wrap 0,1,2,0,...; each rd_nz_count_o matches the reference popcount.

Source files
------------

// File: rtl/dat_chunk_pingpong_if.sv
// Write-beat and whole-chunk read bundle between loader, chunk buffer and sparse PE front end.
// master drives beats and releases; slave is the chunk buffer.
interface dat_chunk_pingpong_if #(
  parameter int MEM_SIZE = 512,
  parameter int BUS_SIZE = 128
);
  localparam int CYC_NUM = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W   = $clog2(MEM_SIZE + 1);
  localparam int BEATS_W = $clog2(CYC_NUM + 1);

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [BUS_SIZE-1:0]   wr_sparsemap_i;
  logic [BUS_SIZE*8-1:0] wr_nonzero_data_i;
  logic                  wr_last_i;
  logic                  rd_valid_o;
  logic [MEM_SIZE-1:0]   rd_sparsemap_o;
  logic [MEM_SIZE*8-1:0] rd_nonzero_data_o;
  logic [CNT_W-1:0]      rd_nz_count_o;
  logic [BEATS_W-1:0]    rd_beats_o;
  logic                  rd_release_i;
  logic                  ovf_o;

  modport master (
    output wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_last_i, rd_release_i,
    input  wr_ready_o, rd_valid_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_count_o,
           rd_beats_o, ovf_o
  );

  modport slave (
    input  wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_last_i, rd_release_i,
    output wr_ready_o, rd_valid_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_count_o,
           rd_beats_o, ovf_o
  );
endinterface

// File: rtl/dat_chunk_pingpong.sv
// Multi-bank chunk buffer: assembles BUS_SIZE beats into MEM_SIZE chunks, presents full chunks with zero read latency.
// Writes stall (wr_ready_o low) while the write bank is still FULL; beats offered then only raise sticky ovf_o.
module dat_chunk_pingpong #(
  parameter int MEM_SIZE = 512,
  parameter int BUS_SIZE = 128,
  parameter int BANK_NUM = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  dat_chunk_pingpong_if.slave bus
);
  localparam int CYC_NUM = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W   = $clog2(MEM_SIZE + 1);
  localparam int BEATS_W = $clog2(CYC_NUM + 1);
  localparam int BEAT_W  = (CYC_NUM > 1) ? $clog2(CYC_NUM) : 1;
  localparam int PTR_W   = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  bank_state_e           state      [BANK_NUM];
  logic [MEM_SIZE-1:0]   bank_sm    [BANK_NUM];
  logic [MEM_SIZE*8-1:0] bank_dat   [BANK_NUM];
  logic [CNT_W-1:0]      bank_cnt   [BANK_NUM];
  logic [BEATS_W-1:0]    bank_beats [BANK_NUM];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [BEAT_W-1:0] beat_cnt;
  logic              ovf_q;

  logic             wr_ready;
  logic             wr_fire;
  logic             wr_close;
  logic             rd_valid;
  logic             rd_fire;
  logic [CNT_W-1:0] beat_pop;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // Ready held low during reset so the loader never sees a beat accepted into a bank being cleared.
  assign wr_ready   = !rst_i && (state[wr_ptr] != FULL);
  assign wr_fire    = bus.wr_valid_i && wr_ready;
  assign wr_close   = (beat_cnt == BEAT_W'(CYC_NUM - 1)) || bus.wr_last_i;
  assign rd_valid   = (state[rd_ptr] == FULL);
  assign rd_fire    = bus.rd_release_i && rd_valid;
  assign beat_pop   = CNT_W'($countones(bus.wr_sparsemap_i));
  assign wr_ptr_nxt = (wr_ptr == PTR_W'(BANK_NUM - 1)) ? '0 : wr_ptr + PTR_W'(1);
  assign rd_ptr_nxt = (rd_ptr == PTR_W'(BANK_NUM - 1)) ? '0 : rd_ptr + PTR_W'(1);

  // A releasing bank is FULL and the write bank never is, so both paths touch different banks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        state[b]      <= EMPTY;
        bank_sm[b]    <= '0;
        bank_dat[b]   <= '0;
        bank_cnt[b]   <= '0;
        bank_beats[b] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.wr_valid_i && !wr_ready) begin
        ovf_q <= 1'b1;
      end

      if (rd_fire) begin
        state[rd_ptr]      <= EMPTY;
        bank_sm[rd_ptr]    <= '0;
        bank_dat[rd_ptr]   <= '0;
        bank_cnt[rd_ptr]   <= '0;
        bank_beats[rd_ptr] <= '0;
        rd_ptr             <= rd_ptr_nxt;
      end

      if (wr_fire) begin
        bank_sm[wr_ptr][BUS_SIZE*int'(beat_cnt) +: BUS_SIZE]      <= bus.wr_sparsemap_i;
        bank_dat[wr_ptr][BUS_SIZE*8*int'(beat_cnt) +: BUS_SIZE*8] <= bus.wr_nonzero_data_i;
        bank_cnt[wr_ptr] <= bank_cnt[wr_ptr] + beat_pop;
        if (wr_close) begin
          state[wr_ptr]      <= FULL;
          bank_beats[wr_ptr] <= BEATS_W'(beat_cnt) + BEATS_W'(1);
          beat_cnt           <= '0;
          wr_ptr             <= wr_ptr_nxt;
        end else begin
          state[wr_ptr] <= FILLING;
          beat_cnt      <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

  assign bus.wr_ready_o        = wr_ready;
  assign bus.rd_valid_o        = rd_valid;
  assign bus.rd_sparsemap_o    = bank_sm[rd_ptr];
  assign bus.rd_nonzero_data_o = bank_dat[rd_ptr];
  assign bus.rd_nz_count_o     = bank_cnt[rd_ptr];
  assign bus.rd_beats_o        = bank_beats[rd_ptr];
  assign bus.ovf_o             = ovf_q;
endmodule

// File: tb/tb_dat_chunk_pingpong.sv
// Randomized bench for dat_chunk_pingpong: a 2-bank default instance and a 3-bank small instance,
// each compared cycle by cycle against a queue-of-chunks reference model.
module tb_dat_chunk_pingpong;
  localparam int AM = 512, AB = 128, AN = 2;
  localparam int AC = AM / AB, AD = AM * 8;
  localparam int ACW = $clog2(AM + 1), ABW = $clog2(AC + 1);
  localparam int BM = 256, BB = 64, BN = 3;
  localparam int BC = BM / BB, BD = BM * 8;
  localparam int BCW = $clog2(BM + 1), BBW = $clog2(BC + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dat_chunk_pingpong_if #(.MEM_SIZE(AM), .BUS_SIZE(AB)) ia ();
  dat_chunk_pingpong_if #(.MEM_SIZE(BM), .BUS_SIZE(BB)) ib ();

  dat_chunk_pingpong #(.MEM_SIZE(AM), .BUS_SIZE(AB), .BANK_NUM(AN)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(ia)
  );
  dat_chunk_pingpong #(.MEM_SIZE(BM), .BUS_SIZE(BB), .BANK_NUM(BN)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(ib)
  );

  // Reference model for instance A: completed chunks waiting for the reader, plus the chunk being built.
  logic [AM-1:0] aq_sm[$];
  logic [AD-1:0] aq_dat[$];
  int            aq_beats[$];
  logic [AM-1:0] a_cur_sm;
  logic [AD-1:0] a_cur_dat;
  int            a_cur_b;
  logic          a_ovf;

  function automatic int ones(input logic [AM-1:0] v);
    int n = 0;
    for (int i = 0; i < AM; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int first_diff(input logic [AD-1:0] x, input logic [AD-1:0] y);
    for (int i = 0; i < AM; i++) if (x[8*i +: 8] !== y[8*i +: 8]) return i;
    return 0;
  endfunction

  function automatic logic [AD-1:0] rnd_vec();
    logic [AD-1:0] r;
    for (int i = 0; i < AD / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic a_model_reset();
    aq_sm.delete();
    aq_dat.delete();
    aq_beats.delete();
    a_cur_sm  = '0;
    a_cur_dat = '0;
    a_cur_b   = 0;
    a_ovf     = 1'b0;
  endtask

  task automatic a_check(input string tag);
    logic           exp_v;
    logic [ACW-1:0] exp_c;
    logic [ABW-1:0] exp_b;
    logic [AD-1:0]  got_d;
    logic [AD-1:0]  exp_d;
    int             idx;
    exp_v = (aq_sm.size() > 0);
    tests++;
    if (ia.rd_valid_o !== exp_v) begin
      fails++;
      $display("FAIL %s rd_valid: got %b expected %b", tag, ia.rd_valid_o, exp_v);
    end
    tests++;
    if (ia.ovf_o !== a_ovf) begin
      fails++;
      $display("FAIL %s ovf: got %b expected %b", tag, ia.ovf_o, a_ovf);
    end
    if (exp_v) begin
      exp_c = ACW'(ones(aq_sm[0]));
      exp_b = ABW'(aq_beats[0]);
      tests++;
      if (ia.rd_sparsemap_o !== aq_sm[0]) begin
        fails++;
        $display("FAIL %s sparsemap: got %h expected %h", tag, ia.rd_sparsemap_o, aq_sm[0]);
      end
      tests++;
      if (ia.rd_nonzero_data_o !== aq_dat[0]) begin
        fails++;
        got_d = ia.rd_nonzero_data_o;
        exp_d = aq_dat[0];
        idx   = first_diff(got_d, exp_d);
        $display("FAIL %s data: element %0d got %h expected %h", tag, idx,
                 got_d[8*idx +: 8], exp_d[8*idx +: 8]);
      end
      tests++;
      if (ia.rd_nz_count_o !== exp_c) begin
        fails++;
        $display("FAIL %s nz_count: got %0d expected %0d", tag, ia.rd_nz_count_o, exp_c);
      end
      tests++;
      if (ia.rd_beats_o !== exp_b) begin
        fails++;
        $display("FAIL %s beats: got %0d expected %0d", tag, ia.rd_beats_o, exp_b);
      end
    end
  endtask

  // One clock of instance A: drive, predict ready, step, update model, compare outputs.
  task automatic a_cycle(input logic vld, input logic [AB-1:0] sm, input logic [AB*8-1:0] dat,
                         input logic last, input logic rel, input string tag);
    logic rdy;
    ia.wr_valid_i        = vld;
    ia.wr_sparsemap_i    = sm;
    ia.wr_nonzero_data_i = dat;
    ia.wr_last_i         = last;
    ia.rd_release_i      = rel;
    rdy = (aq_sm.size() < AN);
    tests++;
    if (ia.wr_ready_o !== rdy) begin
      fails++;
      $display("FAIL %s wr_ready: got %b expected %b", tag, ia.wr_ready_o, rdy);
    end
    @(posedge clk);
    #1;
    if (rel && aq_sm.size() > 0) begin
      void'(aq_sm.pop_front());
      void'(aq_dat.pop_front());
      void'(aq_beats.pop_front());
    end
    if (vld && !rdy) a_ovf = 1'b1;
    if (vld && rdy) begin
      a_cur_sm[AB*a_cur_b +: AB]       = sm;
      a_cur_dat[AB*8*a_cur_b +: AB*8]  = dat;
      if (last || a_cur_b == AC - 1) begin
        aq_sm.push_back(a_cur_sm);
        aq_dat.push_back(a_cur_dat);
        aq_beats.push_back(a_cur_b + 1);
        a_cur_sm  = '0;
        a_cur_dat = '0;
        a_cur_b   = 0;
      end else begin
        a_cur_b++;
      end
    end
    ia.wr_valid_i   = 1'b0;
    ia.wr_last_i    = 1'b0;
    ia.rd_release_i = 1'b0;
    a_check(tag);
  endtask

  task automatic a_random_chunk(input logic release_after, input string tag);
    logic [AD-1:0] r;
    for (int b = 0; b < AC; b++) begin
      r = rnd_vec();
      a_cycle(1'b1, r[AB-1:0], r[AB +: AB*8], 1'b0, 1'b0, tag);
    end
    if (release_after) a_cycle(1'b0, '0, '0, 1'b0, 1'b1, tag);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    a_model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ia.rd_valid_o !== 1'b0 || ia.ovf_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got valid=%b ovf=%b expected 0 0", ia.rd_valid_o, ia.ovf_o);
    end
    tests++;
    if (ia.rd_sparsemap_o !== '0 || ia.rd_nonzero_data_o !== '0) begin
      fails++;
      $display("FAIL reset_data: got nonzero contents expected all zero");
    end
    tests++;
    if (ia.rd_nz_count_o !== '0 || ia.rd_beats_o !== '0) begin
      fails++;
      $display("FAIL reset_counts: got cnt=%0d beats=%0d expected 0 0", ia.rd_nz_count_o, ia.rd_beats_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (ia.wr_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", ia.wr_ready_o);
    end
    a_check("reset_after");
  endtask

  task automatic test_full_chunk();
    logic [AB*8-1:0] d;
    logic [AM-1:0]   exp_sm;
    exp_sm = '0;
    for (int b = 0; b < AC; b++) begin
      d = '0;
      d[7:0] = 8'hA0 + 8'(b);
      exp_sm[AB*b] = 1'b1;
      a_cycle(1'b1, AB'(1), d, 1'b0, 1'b0, "full");
    end
    tests++;
    if (ia.rd_sparsemap_o !== exp_sm) begin
      fails++;
      $display("FAIL full_bits: got %h expected %h", ia.rd_sparsemap_o, exp_sm);
    end
    for (int b = 0; b < AC; b++) begin
      tests++;
      if (ia.rd_nonzero_data_o[AB*8*b +: 8] !== 8'hA0 + 8'(b)) begin
        fails++;
        $display("FAIL full_elem%0d: got %h expected %h", AB*b, ia.rd_nonzero_data_o[AB*8*b +: 8], 8'hA0 + 8'(b));
      end
    end
    tests++;
    if (ia.rd_nz_count_o !== ACW'(4) || ia.rd_beats_o !== ABW'(4)) begin
      fails++;
      $display("FAIL full_counts: got cnt=%0d beats=%0d expected 4 4", ia.rd_nz_count_o, ia.rd_beats_o);
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "full_rel");
  endtask

  task automatic test_early_close();
    a_random_chunk(1'b1, "early_pre1");
    a_random_chunk(1'b1, "early_pre2");
    a_cycle(1'b1, '1, '1, 1'b0, 1'b0, "early");
    a_cycle(1'b1, '1, '1, 1'b1, 1'b0, "early");
    tests++;
    if (ia.rd_beats_o !== ABW'(2) || ia.rd_nz_count_o !== ACW'(256)) begin
      fails++;
      $display("FAIL early_counts: got beats=%0d cnt=%0d expected 2 256", ia.rd_beats_o, ia.rd_nz_count_o);
    end
    tests++;
    if (ia.rd_sparsemap_o[AM-1:AM/2] !== '0 || ia.rd_nonzero_data_o[AD-1:AD/2] !== '0) begin
      fails++;
      $display("FAIL early_padding: got stale upper half expected zero");
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "early_rel");
  endtask

  task automatic test_pingpong();
    logic [AD-1:0] r;
    a_random_chunk(1'b0, "pp_a");
    a_random_chunk(1'b0, "pp_b");
    tests++;
    if (ia.wr_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL pp_stall: got ready=%b expected 0", ia.wr_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      r = rnd_vec();
      a_cycle(1'b1, r[AB-1:0], r[AB +: AB*8], 1'b1, 1'b0, "pp_ovf");
    end
    tests++;
    if (ia.ovf_o !== 1'b1) begin
      fails++;
      $display("FAIL pp_ovf_flag: got %b expected 1", ia.ovf_o);
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "pp_rel_a");
    tests++;
    if (ia.wr_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL pp_ready_after: got %b expected 1", ia.wr_ready_o);
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "pp_rel_b");
  endtask

  task automatic test_simultaneous();
    logic [AD-1:0] r;
    do_reset();
    a_random_chunk(1'b0, "sim_a");
    for (int b = 0; b < AC; b++) begin
      r = rnd_vec();
      a_cycle(1'b1, r[AB-1:0], r[AB +: AB*8], 1'b0, (b == AC - 1), "sim_b");
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "sim_rel_b");
    tests++;
    if (ia.rd_sparsemap_o !== '0 || ia.rd_nonzero_data_o !== '0 || ia.rd_nz_count_o !== '0) begin
      fails++;
      $display("FAIL sim_zeroed: got count %0d / nonzero contents expected zeroed bank", ia.rd_nz_count_o);
    end
    r = rnd_vec();
    r[0] = 1'b1;
    a_cycle(1'b1, r[AB-1:0], r[AB +: AB*8], 1'b0, 1'b0, "sim_wrptr");
    tests++;
    if (ia.rd_sparsemap_o[AB-1:0] !== r[AB-1:0]) begin
      fails++;
      $display("FAIL sim_wrptr: got %h expected %h", ia.rd_sparsemap_o[AB-1:0], r[AB-1:0]);
    end
    a_cycle(1'b1, '0, '0, 1'b1, 1'b0, "sim_close");
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "sim_rel");
  endtask

  task automatic test_reset_mid();
    logic [AD-1:0] r;
    a_random_chunk(1'b0, "mid_x");
    for (int b = 0; b < 2; b++) begin
      r = rnd_vec();
      a_cycle(1'b1, r[AB-1:0], r[AB +: AB*8], 1'b0, 1'b0, "mid_y");
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (ia.rd_valid_o !== 1'b0 || ia.ovf_o !== 1'b0 || ia.rd_nz_count_o !== '0 || ia.rd_beats_o !== '0) begin
      fails++;
      $display("FAIL mid_flags: got valid=%b ovf=%b cnt=%0d beats=%0d expected 0", ia.rd_valid_o,
               ia.ovf_o, ia.rd_nz_count_o, ia.rd_beats_o);
    end
    tests++;
    if (ia.rd_sparsemap_o !== '0 || ia.rd_nonzero_data_o !== '0) begin
      fails++;
      $display("FAIL mid_data: got nonzero contents expected zero");
    end
    @(posedge clk);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    a_model_reset();
    a_random_chunk(1'b0, "mid_fresh");
    tests++;
    if (ia.rd_beats_o !== ABW'(4)) begin
      fails++;
      $display("FAIL mid_beats: got %0d expected 4", ia.rd_beats_o);
    end
    a_cycle(1'b0, '0, '0, 1'b0, 1'b1, "mid_rel");
  endtask

  task automatic test_random_traffic();
    logic [AD-1:0] r;
    logic [AB-1:0] m;
    for (int i = 0; i < 200; i++) begin
      r = rnd_vec();
      m = r[AB-1:0] & r[AB*9 +: AB];
      a_cycle(($urandom_range(0, 3) != 0), m, r[AB +: AB*8], ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0), "rand");
    end
  endtask

  task automatic test_three_banks();
    logic [BM-1:0] q_sm[$];
    logic [BD-1:0] q_dat[$];
    int            q_beats[$];
    logic [BM-1:0] c_sm;
    logic [BD-1:0] c_dat;
    logic [AD-1:0] r;
    logic          vld, last, rel, rdy;
    int            c_b, closed, released, cyc;
    c_sm = '0; c_dat = '0; c_b = 0; closed = 0; released = 0; cyc = 0;
    while (released < 7 && cyc < 2000) begin
      cyc++;
      r    = rnd_vec();
      vld  = (closed < 7) && ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 3) == 0);
      rel  = ($urandom_range(0, 4) == 0) || (closed == 7);
      ib.wr_valid_i        = vld;
      ib.wr_sparsemap_i    = r[BB-1:0];
      ib.wr_nonzero_data_i = r[BB +: BB*8];
      ib.wr_last_i         = last;
      ib.rd_release_i      = rel;
      rdy = (q_sm.size() < BN);
      tests++;
      if (ib.wr_ready_o !== rdy) begin
        fails++;
        $display("FAIL b3_ready cyc %0d: got %b expected %b", cyc, ib.wr_ready_o, rdy);
      end
      @(posedge clk);
      #1;
      if (rel && q_sm.size() > 0) begin
        void'(q_sm.pop_front());
        void'(q_dat.pop_front());
        void'(q_beats.pop_front());
        released++;
      end
      if (vld && rdy) begin
        c_sm[BB*c_b +: BB]      = r[BB-1:0];
        c_dat[BB*8*c_b +: BB*8] = r[BB +: BB*8];
        if (last || c_b == BC - 1) begin
          q_sm.push_back(c_sm);
          q_dat.push_back(c_dat);
          q_beats.push_back(c_b + 1);
          c_sm = '0; c_dat = '0; c_b = 0;
          closed++;
        end else begin
          c_b++;
        end
      end
      ib.wr_valid_i   = 1'b0;
      ib.wr_last_i    = 1'b0;
      ib.rd_release_i = 1'b0;
      tests++;
      if (ib.rd_valid_o !== (q_sm.size() > 0)) begin
        fails++;
        $display("FAIL b3_valid cyc %0d: got %b expected %b", cyc, ib.rd_valid_o, (q_sm.size() > 0));
      end
      if (q_sm.size() > 0) begin
        tests++;
        if (ib.rd_nz_count_o !== BCW'(ones(AM'(q_sm[0])))) begin
          fails++;
          $display("FAIL b3_count chunk %0d: got %0d expected %0d", released, ib.rd_nz_count_o, ones(AM'(q_sm[0])));
        end
        tests++;
        if (ib.rd_sparsemap_o !== q_sm[0] || ib.rd_nonzero_data_o !== q_dat[0]) begin
          fails++;
          $display("FAIL b3_contents chunk %0d: got sm %h expected %h", released, ib.rd_sparsemap_o, q_sm[0]);
        end
        tests++;
        if (ib.rd_beats_o !== BBW'(q_beats[0])) begin
          fails++;
          $display("FAIL b3_beats chunk %0d: got %0d expected %0d", released, ib.rd_beats_o, q_beats[0]);
        end
      end
    end
    tests++;
    if (released != 7) begin
      fails++;
      $display("FAIL b3_timeout: got %0d chunks released expected 7", released);
    end
  endtask

  initial begin
    ia.wr_valid_i = 1'b0; ia.wr_sparsemap_i = '0; ia.wr_nonzero_data_i = '0;
    ia.wr_last_i  = 1'b0; ia.rd_release_i   = 1'b0;
    ib.wr_valid_i = 1'b0; ib.wr_sparsemap_i = '0; ib.wr_nonzero_data_i = '0;
    ib.wr_last_i  = 1'b0; ib.rd_release_i   = 1'b0;
    a_model_reset();
    test_reset();
    test_full_chunk();
    test_early_close();
    test_pingpong();
    test_simultaneous();
    test_reset_mid();
    test_random_traffic();
    test_three_banks();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
